// File: rtl/fifo_goal_pkg.sv
// Shared state encoding and reward constants for the FIFO goal-seeking episode monitor.
// Combinational definitions only: no latency and no backpressure.
package fifo_goal_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEEK_FULL  = 2'd1,
    SEEK_EMPTY = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic signed [7:0] R_STEP    = -8'sd1;
  localparam logic signed [7:0] R_FULL    =  8'sd10;
  localparam logic signed [7:0] R_EMPTY   =  8'sd20;
  localparam logic signed [7:0] R_ILLEGAL = -8'sd5;
  localparam logic signed [7:0] R_TIMEOUT = -8'sd20;

  localparam logic [7:0] ILLEGAL_MAX = 8'd255;

endpackage

// File: rtl/fifo_shadow_occ.sv
// Shadow FIFO occupancy: saturating occ register, an illegal-action flag and the raw next occupancy.
// occ updates one cycle after an enabled action; flag and next_occ are combinational; no backpressure.
module fifo_shadow_occ
  import fifo_goal_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_push,
  input  logic                 i_pop,
  output logic                 o_illegal,
  output logic [LOG2DEPTH:0]   o_next_occ
);

  localparam int OW = LOG2DEPTH + 1;
  localparam logic [LOG2DEPTH:0] OCC_MAX = OW'(DEPTH);
  localparam logic [LOG2DEPTH:0] OCC_ONE = OW'(1);

  logic [LOG2DEPTH:0] r_occ;
  logic               w_inc;
  logic               w_dec;

  assign w_inc = i_push & ~i_pop;
  assign w_dec = i_pop & ~i_push;

  // Raw next value wraps on purpose; the saturated value is simply "hold" when the action is illegal.
  always_comb begin
    o_next_occ = r_occ;
    if (w_inc) begin
      o_next_occ = r_occ + OCC_ONE;
    end else if (w_dec) begin
      o_next_occ = r_occ - OCC_ONE;
    end
  end

  assign o_illegal = (w_inc && (r_occ == OCC_MAX)) || (w_dec && (r_occ == '0));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_occ <= '0;
    end else if (i_en && !o_illegal) begin
      r_occ <= o_next_occ;
    end
  end

endmodule

// File: rtl/fifo_goal_monitor.sv
// Episode FSM and per-step reward for an agent driving a FIFO to full then empty; all outputs registered.
// One-cycle latency from sampled inputs; no backpressure, every cycle is observed.
module fifo_goal_monitor
  import fifo_goal_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ack,
  input  logic                 push,
  input  logic                 pop,
  input  logic [LOG2DEPTH:0]   count,
  input  logic                 full_posedge,
  input  logic                 empty_posedge,
  output logic [1:0]           state,
  output logic signed [7:0]    reward,
  output logic                 reward_valid,
  output logic [STEP_W-1:0]    step_cnt,
  output logic                 done,
  output logic                 goal_met,
  output logic                 timeout,
  output logic [7:0]           illegal_cnt,
  output logic                 cnt_err
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic signed [7:0]   r_reward;
  logic                r_reward_vld;
  logic [STEP_W-1:0]   r_step;
  logic                r_done;
  logic                r_goal_met;
  logic                r_timeout;
  logic [7:0]          r_illegal_cnt;
  logic                r_cnt_err;

  logic                w_seek;
  logic                w_start_go;
  logic                w_full_goal;
  logic                w_empty_goal;
  logic                w_timeout;
  logic                w_illegal;
  logic [LOG2DEPTH:0]  w_next_occ;
  logic signed [7:0]   w_reward;

  fifo_shadow_occ #(
    .DEPTH     (DEPTH),
    .LOG2DEPTH (LOG2DEPTH)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_go),
    .i_en       (w_seek),
    .i_push     (push),
    .i_pop      (pop),
    .o_illegal  (w_illegal),
    .o_next_occ (w_next_occ)
  );

  assign w_seek       = (r_state == SEEK_FULL) || (r_state == SEEK_EMPTY);
  assign w_start_go   = (r_state == IDLE) && start;
  assign w_full_goal  = (r_state == SEEK_FULL) && full_posedge;
  assign w_empty_goal = (r_state == SEEK_EMPTY) && empty_posedge;
  // A goal reached on the last budgeted step counts as a goal, not a timeout.
  assign w_timeout    = w_seek && !w_full_goal && !w_empty_goal && (r_step == STEP_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (start) w_next_state = SEEK_FULL;
      SEEK_FULL:  if (w_full_goal) w_next_state = SEEK_EMPTY;
                  else if (w_timeout) w_next_state = DONE;
      SEEK_EMPTY: if (w_empty_goal || w_timeout) w_next_state = DONE;
      DONE:       if (ack) w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_reward = R_STEP;
    if (w_full_goal)  w_reward = w_reward + R_FULL;
    if (w_empty_goal) w_reward = w_reward + R_EMPTY;
    if (w_illegal)    w_reward = w_reward + R_ILLEGAL;
    if (w_timeout)    w_reward = w_reward + R_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_reward      <= '0;
      r_reward_vld  <= 1'b0;
      r_step        <= '0;
      r_done        <= 1'b0;
      r_goal_met    <= 1'b0;
      r_timeout     <= 1'b0;
      r_illegal_cnt <= '0;
      r_cnt_err     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_done       <= (w_next_state == DONE);
      r_reward_vld <= w_seek;
      r_reward     <= w_seek ? w_reward : 8'sd0;
      if (w_start_go) begin
        r_step        <= '0;
        r_illegal_cnt <= '0;
        r_goal_met    <= 1'b0;
        r_timeout     <= 1'b0;
        r_cnt_err     <= 1'b0;
      end else if (w_seek) begin
        if (r_step != '1) r_step <= r_step + STEP_ONE;
        if (w_illegal && (r_illegal_cnt != ILLEGAL_MAX)) r_illegal_cnt <= r_illegal_cnt + 8'd1;
        if (count != w_next_occ) r_cnt_err <= 1'b1;
        if (w_empty_goal) r_goal_met <= 1'b1;
        if (w_timeout) r_timeout <= 1'b1;
      end
    end
  end

  assign state        = r_state;
  assign reward       = r_reward;
  assign reward_valid = r_reward_vld;
  assign step_cnt     = r_step;
  assign done         = r_done;
  assign goal_met     = r_goal_met;
  assign timeout      = r_timeout;
  assign illegal_cnt  = r_illegal_cnt;
  assign cnt_err      = r_cnt_err;

endmodule

// File: tb/tb_fifo_goal_monitor.sv
// Bench for fifo_goal_monitor: directed table, corner sequences and random stimulus against a behavioural model.
module tb_fifo_goal_monitor;

  localparam int DEPTH     = 8;
  localparam int LOG2DEPTH = 3;
  localparam int MAX_STEPS = 64;
  localparam int STEP_W    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, ack, push, pop, full_posedge, empty_posedge;
  logic [LOG2DEPTH:0]   count;
  logic [1:0]           state;
  logic signed [7:0]    reward;
  logic                 reward_valid;
  logic [STEP_W-1:0]    step_cnt;
  logic                 done, goal_met, timeout, cnt_err;
  logic [7:0]           illegal_cnt;

  fifo_goal_monitor #(
    .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH), .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .push(push), .pop(pop),
    .count(count), .full_posedge(full_posedge), .empty_posedge(empty_posedge),
    .state(state), .reward(reward), .reward_valid(reward_valid), .step_cnt(step_cnt),
    .done(done), .goal_met(goal_met), .timeout(timeout), .illegal_cnt(illegal_cnt),
    .cnt_err(cnt_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: episode described with plain integers.
  int m_state, m_step, m_ill, m_occ, m_rew, m_rv, m_goal, m_tmo, m_cerr;
  // Stand-in for the real FIFO the agent drives.
  int f_occ;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model(input bit r, input bit st, input bit ak, input bit pu, input bit po,
                                input int c, input bit fp, input bit ep);
    int delta, raw;
    bit ill, fullg, emptyg, tmo;
    if (r) begin
      m_state = 0; m_step = 0; m_ill = 0; m_occ = 0; m_rew = 0;
      m_rv = 0; m_goal = 0; m_tmo = 0; m_cerr = 0;
      return;
    end
    if (m_state == 1 || m_state == 2) begin
      delta  = (pu && !po) ? 1 : ((po && !pu) ? -1 : 0);
      ill    = (delta == 1 && m_occ == DEPTH) || (delta == -1 && m_occ == 0);
      raw    = (m_occ + delta + 16) % 16;
      fullg  = (m_state == 1) && fp;
      emptyg = (m_state == 2) && ep;
      tmo    = !fullg && !emptyg && (m_step == MAX_STEPS - 1);
      m_rew  = -1 + (fullg ? 10 : 0) + (emptyg ? 20 : 0) - (ill ? 5 : 0) - (tmo ? 20 : 0);
      m_rv   = 1;
      if (c != raw) m_cerr = 1;
      if (ill && m_ill < 255) m_ill++;
      if (!ill) m_occ = m_occ + delta;
      m_step++;
      if (fullg) m_state = 2;
      else if (emptyg) begin m_state = 3; m_goal = 1; end
      else if (tmo) begin m_state = 3; m_tmo = 1; end
    end else begin
      m_rv = 0; m_rew = 0;
      if (m_state == 0 && st) begin
        m_state = 1; m_step = 0; m_ill = 0; m_goal = 0; m_tmo = 0; m_cerr = 0; m_occ = 0;
      end else if (m_state == 3 && ak) begin
        m_state = 0;
      end
    end
  endfunction

  task automatic compare_all();
    chk("state", int'(state), m_state);
    chk("reward_valid", int'(reward_valid), m_rv);
    chk("reward", int'(reward), m_rew);
    chk("step_cnt", int'(step_cnt), m_step);
    chk("done", int'(done), (m_state == 3) ? 1 : 0);
    chk("goal_met", int'(goal_met), m_goal);
    chk("timeout", int'(timeout), m_tmo);
    chk("illegal_cnt", int'(illegal_cnt), m_ill);
    chk("cnt_err", int'(cnt_err), m_cerr);
  endtask

  task automatic drive(input bit r, input bit st, input bit ak, input bit pu, input bit po,
                       input int cval, input bit fp, input bit ep);
    @(negedge clk);
    rst = r; start = st; ack = ak; push = pu; pop = po;
    count = cval[LOG2DEPTH:0]; full_posedge = fp; empty_posedge = ep;
    model(r, st, ak, pu, po, cval, fp, ep);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // One cycle of agent action against the stand-in FIFO; force_cnt >= 0 overrides the reported count.
  task automatic fstep(input bit st, input bit ak, input bit pu, input bit po, input int force_cnt);
    int prev;
    bit fp, ep;
    prev = f_occ;
    if (pu && !po && f_occ < DEPTH) f_occ++;
    else if (po && !pu && f_occ > 0) f_occ--;
    fp = (prev < DEPTH) && (f_occ == DEPTH);
    ep = (prev > 0) && (f_occ == 0);
    drive(1'b0, st, ak, pu, po, (force_cnt >= 0) ? force_cnt : f_occ, fp, ep);
  endtask

  task automatic reset_all();
    f_occ = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit st, ak, pu, po;
    int e_state, e_rv, e_rew, e_step;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int r, fc;
    bit st, ak, pu, po;

    rst = 1'b1; start = 1'b0; ack = 1'b0; push = 1'b0; pop = 1'b0;
    count = '0; full_posedge = 1'b0; empty_posedge = 1'b0;
    f_occ = 0;

    // Full-then-empty episode, then start ignored in DONE, then ack.
    tbl[0] = '{1, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 1; i <= 7; i++) tbl[i] = '{0, 0, 1, 0, 1, 1, -1, i};
    tbl[8] = '{0, 0, 1, 0, 2, 1, 9, 8};
    for (int i = 9; i <= 15; i++) tbl[i] = '{0, 0, 0, 1, 2, 1, -1, i};
    tbl[16] = '{0, 0, 0, 1, 3, 1, 19, 16};
    tbl[17] = '{1, 0, 0, 0, 3, 0, 0, 16};
    tbl[18] = '{0, 1, 0, 0, 0, 0, 0, 16};

    reset_all();
    for (int i = 0; i < 19; i++) begin
      fstep(tbl[i].st, tbl[i].ak, tbl[i].pu, tbl[i].po, -1);
      chk("tbl_state", int'(state), tbl[i].e_state);
      chk("tbl_rv", int'(reward_valid), tbl[i].e_rv);
      chk("tbl_reward", int'(reward), tbl[i].e_rew);
      chk("tbl_step", int'(step_cnt), tbl[i].e_step);
      if (i == 16) chk("tbl_goal_met", int'(goal_met), 1);
    end

    // Timeout after the full step budget with no goal.
    reset_all();
    fstep(1, 0, 0, 0, -1);
    for (int i = 0; i < MAX_STEPS; i++) begin
      fstep(0, 0, 0, 0, -1);
      if (i == MAX_STEPS - 2) begin
        chk("tmo_prev_reward", int'(reward), -1);
        chk("tmo_prev_state", int'(state), 1);
      end
      if (i == MAX_STEPS - 1) begin
        chk("tmo_state", int'(state), 3);
        chk("tmo_flag", int'(timeout), 1);
        chk("tmo_reward", int'(reward), -21);
        chk("tmo_step", int'(step_cnt), 64);
      end
    end

    // Illegal pops on empty and an illegal push on full.
    reset_all();
    fstep(1, 0, 0, 0, -1);
    fstep(0, 0, 0, 1, -1);
    chk("ill_pop1_reward", int'(reward), -6);
    fstep(0, 0, 0, 1, -1);
    chk("ill_pop2_reward", int'(reward), -6);
    chk("ill_pop2_cnt", int'(illegal_cnt), 2);
    for (int i = 0; i < DEPTH; i++) fstep(0, 0, 1, 0, -1);
    chk("ill_full_state", int'(state), 2);
    fstep(0, 0, 1, 0, -1);
    chk("ill_push_cnt", int'(illegal_cnt), 3);
    chk("ill_push_reward", int'(reward), -6);

    // Count disagreement is sticky across the episode and cleared only by the next start.
    reset_all();
    fstep(1, 0, 0, 0, -1);
    fstep(0, 0, 1, 0, 3);
    chk("cerr_set", int'(cnt_err), 1);
    fstep(0, 0, 0, 1, -1);
    chk("cerr_hold", int'(cnt_err), 1);
    for (int i = 0; i < MAX_STEPS - 2; i++) fstep(0, 0, 0, 0, -1);
    chk("cerr_done_state", int'(state), 3);
    fstep(0, 1, 0, 0, -1);
    chk("cerr_idle_hold", int'(cnt_err), 1);
    fstep(1, 0, 0, 0, -1);
    chk("cerr_cleared", int'(cnt_err), 0);

    // Reset mid-episode overrides a simultaneous start and push.
    reset_all();
    fstep(1, 0, 0, 0, -1);
    for (int i = 0; i < DEPTH; i++) fstep(0, 0, 1, 0, -1);
    for (int i = 0; i < 12; i++) fstep(0, 0, 0, 0, -1);
    chk("rst_pre_state", int'(state), 2);
    chk("rst_pre_step", int'(step_cnt), 20);
    f_occ = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_step", int'(step_cnt), 0);
    chk("rst_rv", int'(reward_valid), 0);
    chk("rst_reward", int'(reward), 0);

    // Random agent behaviour with occasional count corruption and resets.
    reset_all();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        reset_all();
      end else begin
        st = ($urandom_range(0, 7) == 0);
        ak = ($urandom_range(0, 3) == 0);
        pu = 1'($urandom_range(0, 1));
        po = 1'($urandom_range(0, 1));
        fc = ($urandom_range(0, 39) == 0) ? $urandom_range(0, DEPTH) : -1;
        fstep(st, ak, pu, po, fc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_goal_monitor.md
FIFO_GOAL_MONITOR -- requirements
Module: fifo_goal_monitor

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth under observation.
REQ-002 Parameter LOG2DEPTH, default 3, log2 of DEPTH.
REQ-003 Parameter MAX_STEPS, default 64, episode step budget.
REQ-004 Parameter STEP_W, default 8, width of step counter.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin episode (honoured in IDLE only).
REQ-008 ack  in  1  agent acknowledge of done (honoured in DONE only).
REQ-009 push, pop  in  1 each  actions applied to the FIFO this cycle.
REQ-010 count  in  LOG2DEPTH+1  FIFO count output (post-action occupancy, same cycle).
REQ-011 full_posedge, empty_posedge  in  1 each  FIFO edge flags, same cycle.
REQ-012 state  out  2  FSM state encoding.
REQ-013 reward  out  8 signed  per-step reward; reward_valid  out  1  qualifier.
REQ-014 step_cnt  out  STEP_W  steps taken in current episode.
REQ-015 done, goal_met, timeout  out  1 each  episode status; illegal_cnt  out  8; cnt_err  out  1 sticky.

Function
REQ-016 FSM states IDLE=0, SEEK_FULL=1, SEEK_EMPTY=2, DONE=3; "seek" means state 1 or 2.
REQ-017 IDLE->SEEK_FULL on start; on that transition clear step_cnt, illegal_cnt, goal_met, timeout, cnt_err, shadow occupancy.
REQ-018 SEEK_FULL->SEEK_EMPTY on full_posedge; SEEK_EMPTY->DONE with goal_met=1 on empty_posedge.
REQ-019 Seek state with step_cnt==MAX_STEPS-1 and no goal event -> DONE with timeout=1; goal event wins over timeout in the same cycle.
REQ-020 empty_posedge in SEEK_FULL and full_posedge in SEEK_EMPTY cause no transition and no bonus.
REQ-021 DONE->IDLE on ack; done=1 exactly while in DONE; goal_met/timeout hold until next start.
REQ-022 start outside IDLE and ack outside DONE are ignored.
REQ-023 In seek states step_cnt increments by 1 every cycle, never wraps within an episode.
REQ-024 Shadow occupancy occ (LOG2DEPTH+1 bits): push&!pop -> occ+1 saturating at DEPTH; pop&!push -> occ-1 saturating at 0; else hold.
REQ-025 Illegal action: push&!pop with occ==DEPTH, or pop&!push with occ==0; illegal_cnt increments (saturating at 255) in seek states.
REQ-026 cnt_err sets when in a seek state count != next value of occ computed per REQ-024 ignoring saturation; sticky until start.
REQ-027 Reward per seek cycle = -1 base, +10 full goal, +20 empty goal, -5 illegal, -20 timeout, summed; range fits 8-bit signed.
REQ-028 reward and reward_valid registered: valid=1 the cycle after each seek-state cycle, 0 otherwise; reward=0 when valid=0.
REQ-029 All outputs registered; one-cycle latency from sampled inputs.

Reset
REQ-030 rst wins over all inputs, including mid-episode; next state IDLE.
REQ-031 Reset values: state=IDLE, reward=0, reward_valid=0, step_cnt=0, done=0, goal_met=0, timeout=0, illegal_cnt=0, cnt_err=0, occ=0.

Structure
REQ-032 Package fifo_goal_pkg holds state encoding and reward constants (R_STEP, R_FULL, R_EMPTY, R_ILLEGAL, R_TIMEOUT).
REQ-033 Sub-module fifo_shadow_occ implements REQ-024/REQ-025 (occ, illegal flag, next_occ); FSM and reward in top.
REQ-034 Implementation 120-400 RTL lines; no latches, no multi-cycle paths.

Verification
REQ-035 start, 8 push cycles (count 1..8, full_posedge at 8th) -> state SEEK_EMPTY, reward +9 on that step, step_cnt=8.
REQ-036 Continue 8 pop cycles (empty_posedge at 8th) -> state DONE, goal_met=1, reward +19 final step; ack -> IDLE.
REQ-037 start, idle 64 cycles -> DONE at step 64, timeout=1, final reward -21, prior rewards -1 each.
REQ-038 start, pop with occ=0 twice -> illegal_cnt=2, reward -6 each; push at occ=8 -> illegal_cnt increments.
REQ-039 count driven 3 while occ path expects 1 -> cnt_err=1, stays set until next start.
REQ-040 rst asserted in SEEK_EMPTY at step 20 -> next cycle all outputs at REQ-031 values; start ignored in DONE.
